// File: rtl/seq_scan_ctrl_if.sv
// rtl/seq_scan_ctrl_if.sv - config, control, serial stream and status bundle for seq_scan_ctrl
interface seq_scan_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) ();
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [WIN_W-1:0] cfg_len;
    logic             start;
    logic             stop;
    logic             bit_in;
    logic             bit_vld;
    logic             busy;
    logic             done;
    logic             match_pulse;
    logic [CNT_W-1:0] match_count;
    logic             overflow;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, start, stop, bit_in, bit_vld,
        input  busy, done, match_pulse, match_count, overflow
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, start, stop, bit_in, bit_vld,
        output busy, done, match_pulse, match_count, overflow
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - windowed serial pattern scan controller with match counting
// Optional SEQ_NONOVERLAP_EN: restart pattern fill after every match (non-overlapping detection).
module seq_scan_ctrl #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter int               WIN_W   = 16,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011
) (
    input logic           clk,
    input logic           rst,
    seq_scan_ctrl_if.slave bus
);
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_n;
    logic [PAT_W-1:0]    r_pattern, w_pattern_n;
    logic [WIN_W-1:0]    r_len, w_len_n;
    logic [PAT_W-1:0]    r_hist, w_hist_n;
    logic [FILL_W-1:0]   r_fill, w_fill_n;
    logic [WIN_W-1:0]    r_samp, w_samp_n;
    logic [CNT_W-1:0]    r_count, w_count_n;
    logic                r_ovf, w_ovf_n;
    logic                r_pulse, w_pulse_n;
    logic                r_busy, r_done;
    logic [WIN_W-1:0]    w_eff_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pattern <= PAT_RST;
            r_len     <= '0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_samp    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_pattern <= w_pattern_n;
            r_len     <= w_len_n;
            r_hist    <= w_hist_n;
            r_fill    <= w_fill_n;
            r_samp    <= w_samp_n;
            r_count   <= w_count_n;
            r_ovf     <= w_ovf_n;
            r_pulse   <= w_pulse_n;
            r_busy    <= (w_state_n == S_RUN);
            r_done    <= (w_state_n == S_DONE);
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_pattern_n = r_pattern;
        w_len_n     = r_len;
        w_hist_n    = r_hist;
        w_fill_n    = r_fill;
        w_samp_n    = r_samp;
        w_count_n   = r_count;
        w_ovf_n     = r_ovf;
        w_pulse_n   = 1'b0;
        w_eff_len   = bus.cfg_we ? bus.cfg_len : r_len;

        case (r_state)
            S_IDLE: begin
                if (bus.cfg_we) begin
                    w_pattern_n = bus.cfg_pattern;
                    w_len_n     = bus.cfg_len;
                end
                if (bus.start) begin
                    w_count_n = '0;
                    w_ovf_n   = 1'b0;
                    w_hist_n  = '0;
                    w_fill_n  = '0;
                    w_samp_n  = '0;
                    w_state_n = (w_eff_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // stop wins over a valid sample in the same cycle; that sample is dropped
                if (bus.stop) begin
                    w_state_n = S_DONE;
                end else if (bus.bit_vld) begin
                    w_hist_n = {r_hist[PAT_W-2:0], bus.bit_in};
                    w_fill_n = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
                    w_samp_n = r_samp + 1'b1;
                    if ((w_fill_n == FILL_FULL) && (w_hist_n == r_pattern)) begin
                        w_pulse_n = 1'b1;
                        if (r_count == CNT_MAX) begin
                            w_ovf_n = 1'b1;
                        end else begin
                            w_count_n = r_count + 1'b1;
                        end
`ifdef SEQ_NONOVERLAP_EN
                        w_fill_n = '0;
`endif
                    end
                    if (w_samp_n == r_len) begin
                        w_state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.match_pulse = r_pulse;
    assign bus.match_count = r_count;
    assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - directed bench for seq_scan_ctrl with a per-cycle window model
module tb_seq_scan_ctrl;
    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam int WIN_W = 16;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   npulse = 0;
    int   ndone  = 0;

    seq_scan_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .PAT_RST(4'b1011)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: the accepted bits of the window are kept as a list; a match is the last PAT_W bits equal to the pattern.
    int   m_phase;
    int   m_pat;
    int   m_len;
    int   m_taken;
    int   m_count;
    int   m_ovf;
    int   m_pulse;
    bit   m_bits[$];

    function automatic int tail_value();
        int v = 0;
        for (int k = m_bits.size() - PAT_W; k < m_bits.size(); k++) v = (v << 1) | int'(m_bits[k]);
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_pat = 'b1011; m_len = 0; m_taken = 0;
            m_count = 0; m_ovf = 0; m_pulse = 0; m_bits.delete();
        end else begin
            m_pulse = 0;
            if (m_phase == 0) begin
                if (bus.cfg_we) begin
                    m_pat = int'(bus.cfg_pattern);
                    m_len = int'(bus.cfg_len);
                end
                if (bus.start) begin
                    m_count = 0; m_ovf = 0; m_taken = 0; m_bits.delete();
                    m_phase = (m_len == 0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (bus.stop) begin
                    m_phase = 2;
                end else if (bus.bit_vld) begin
                    m_bits.push_back(bus.bit_in);
                    m_taken++;
                    if (m_bits.size() >= PAT_W && tail_value() == m_pat) begin
                        m_pulse = 1;
                        if (m_count == MAXC) m_ovf = 1;
                        else m_count++;
`ifdef SEQ_NONOVERLAP_EN
                        m_bits.delete();
`endif
                    end
                    if (m_taken == m_len) m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",        int'(bus.busy),        int'(m_phase == 1));
        chk("done",        int'(bus.done),        int'(m_phase == 2));
        chk("match_pulse", int'(bus.match_pulse), m_pulse);
        chk("match_count", int'(bus.match_count), m_count);
        chk("overflow",    int'(bus.overflow),    m_ovf);
    end

    always @(posedge clk) begin
        if (bus.match_pulse) npulse++;
        if (bus.done) ndone++;
    end

    task automatic send(input logic [127:0] seq, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            bus.bit_in  = seq[n-1-i];
            bus.bit_vld = 1'b1;
            @(negedge clk);
            bus.bit_vld = 1'b0;
            if (gap && i < n - 1) @(negedge clk);
        end
    endtask

    task automatic scan(input logic [3:0] pat, input int len, input logic [127:0] seq, input int n, input bit gap);
        npulse          = 0;
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = WIN_W'(len);
        bus.start       = 1'b1;
        @(negedge clk);
        bus.cfg_we      = 1'b0;
        bus.start       = 1'b0;
        send(seq, n, gap);
    endtask

    int ndone_before;

    initial begin
        bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0;
        bus.start = 0; bus.stop = 0; bus.bit_in = 0; bus.bit_vld = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_count", int'(bus.match_count), 0);

        // zero-length window: done straight from start
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("t1_done", int'(bus.done), 1);
        chk("t1_busy", int'(bus.busy), 0);
        @(negedge clk);
        chk("t1_done_end", int'(bus.done), 0);

        scan(4'b1011, 10, 128'b1011011011, 10, 1'b0);
        chk("t2_done", int'(bus.done), 1);
        @(negedge clk);
`ifdef SEQ_NONOVERLAP_EN
        chk("t2_count", int'(bus.match_count), 2);
        chk("t2_pulses", npulse, 2);
`else
        chk("t2_count", int'(bus.match_count), 3);
        chk("t2_pulses", npulse, 3);
`endif
        chk("t2_model", m_count, int'(npulse));

        scan(4'b1011, 10, 128'b1011011011, 10, 1'b1);
        chk("t3_done", int'(bus.done), 1);
        @(negedge clk);
`ifdef SEQ_NONOVERLAP_EN
        chk("t3_pulses", npulse, 2);
`else
        chk("t3_pulses", npulse, 3);
`endif

        scan(4'b0000, 20, 128'b0, 20, 1'b0);
        @(negedge clk);
        chk("t4_count", int'(bus.match_count), 3);
        chk("t4_ovf", int'(bus.overflow), 1);
`ifdef SEQ_NONOVERLAP_EN
        chk("t4_pulses", npulse, 5);
`else
        chk("t4_pulses", npulse, 17);
`endif

        // stop drops its own sample; cfg_we/start in RUN are ignored
        scan(4'b1011, 100, 128'b10, 2, 1'b0);
        bus.bit_in = 1'b1; bus.bit_vld = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_pattern = 4'b0000; bus.cfg_len = 16'd4; bus.start = 1'b1;
        @(negedge clk);
        bus.bit_vld = 1'b0; bus.cfg_we = 1'b0; bus.start = 1'b0;
        send(128'b101, 3, 1'b0);
        bus.stop = 1'b1; bus.bit_vld = 1'b1; bus.bit_in = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0; bus.bit_vld = 1'b0;
        chk("t5_done", int'(bus.done), 1);
        chk("t5_count", int'(bus.match_count), 1);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send(128'b1011, 4, 1'b0);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("t5_pattern_kept", int'(bus.match_count), 1);
        @(negedge clk);

        scan(4'b0110, 100, 128'b01100110, 8, 1'b0);
        chk("t6_pulse_pre", int'(bus.match_pulse), 1);
        chk("t6_count_pre", int'(bus.match_count), 2);
        ndone_before = ndone;
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_count", int'(bus.match_count), 0);
        chk("t6_pulse", int'(bus.match_pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_done", ndone, ndone_before);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
